// File: rtl/vga_pattern_gen.sv
// VGA timing generator with a frame-synchronous test-pattern source.
// Produces vertical/horizontal stripes, a checkerboard, or a moving box. All outputs lag the counters by one clock.
module vga_pattern_gen #(
  parameter int   H_ACTIVE    = 1024,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BP        = 160,
  parameter int   V_ACTIVE    = 768,
  parameter int   V_FP        = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BP        = 29,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   CW          = 11,
  parameter int   STRIPE_LOG2 = 6,
  parameter int   BOX         = 64
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [1:0]    mode,
  output logic          hsync,
  output logic          vsync,
  output logic          vidon,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {
    MODE_VSTRIPE = 2'd0,
    MODE_HSTRIPE = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BOX_W    = CW'(BOX);
  localparam logic [CW-1:0] BOX_TOP  = CW'((V_ACTIVE - BOX) / 2);
  localparam logic [CW-1:0] BOX_BOT  = CW'((V_ACTIVE + BOX) / 2);
  localparam logic [CW-1:0] BX_MAX   = CW'(H_ACTIVE - BOX);

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] bx_q, bx_d, bx_end;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, vidon_q, vidon_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  mode_e         mode_q, mode_d;
  logic          last_col, last_row, frame_end, in_box;
  logic [2:0]    h_idx, v_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hcnt_d  = hcnt_q + 1'b1;
    vcnt_d  = vcnt_q;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;

    last_col  = (hcnt_q == H_LAST);
    last_row  = (vcnt_q == V_LAST);
    frame_end = last_col && last_row;

    if (last_col) begin
      hcnt_d = '0;
      vcnt_d = last_row ? '0 : vcnt_q + 1'b1;
    end

    hc_d          = hcnt_q;
    vc_d          = vcnt_q;
    hsync_d       = (hcnt_q >= HS_START && hcnt_q < HS_STOP) ? HS_POL : ~HS_POL;
    vsync_d       = (vcnt_q >= VS_START && vcnt_q < VS_STOP) ? VS_POL : ~VS_POL;
    vidon_d       = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);

    h_idx  = hcnt_q[STRIPE_LOG2+2:STRIPE_LOG2];
    v_idx  = vcnt_q[STRIPE_LOG2+2:STRIPE_LOG2];
    bx_end = bx_q + BOX_W;
    in_box = (hcnt_q >= bx_q) && (hcnt_q < bx_end) &&
             (vcnt_q >= BOX_TOP) && (vcnt_q < BOX_BOT);

    unique case (mode_q)
      MODE_VSTRIPE: begin
        red_d   = {4{h_idx[2]}};
        green_d = {4{h_idx[1]}};
        blue_d  = {4{h_idx[0]}};
      end
      MODE_HSTRIPE: begin
        red_d   = {4{v_idx[2]}};
        green_d = {4{v_idx[1]}};
        blue_d  = {4{v_idx[0]}};
      end
      MODE_CHECKER: begin
        red_d   = {4{hcnt_q[STRIPE_LOG2] ^ vcnt_q[STRIPE_LOG2]}};
        green_d = red_d;
        blue_d  = red_d;
      end
      MODE_BOX: begin
        red_d   = {4{in_box}};
        green_d = {4{in_box}};
        blue_d  = 4'hF;
      end
      default: ;
    endcase

    if (!vidon_d) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end

    // Mode, box position and frame count only move on the last pixel so a frame is never torn.
    mode_d      = frame_end ? mode_e'(mode) : mode_q;
    frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    bx_d        = bx_q;
    if (frame_end) bx_d = (bx_q == BX_MAX) ? '0 : bx_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      vidon_q       <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      bx_q          <= '0;
      mode_q        <= MODE_VSTRIPE;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      bx_q          <= bx_d;
      mode_q        <= mode_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vidon       = vidon_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
